// File: rtl/counter_game_pkg.sv
// Shared types for the counter game engine: control codes, winner/loser
// report and FSM states.
package counter_game_pkg;

  typedef enum logic [1:0] {
    CTRL_INC_S = 2'b00,
    CTRL_INC_B = 2'b01,
    CTRL_DEC_S = 2'b10,
    CTRL_DEC_B = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_e;

endpackage

// File: rtl/counter_game_if.sv
// Count interface of the counter game: commands in, counter/score/status out.
interface counter_game_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SCORE_W = 4
);
  logic               INIT;
  logic               en;
  logic [1:0]         control;
  logic [WIDTH-1:0]   load_value;
  logic [WIDTH-1:0]   main_counter;
  logic [SCORE_W-1:0] winner_count;
  logic [SCORE_W-1:0] loser_count;
  logic               WINNER;
  logic               LOSER;
  logic               GAMEOVER;
  logic [1:0]         WHO;

  modport master (
    output INIT, en, control, load_value,
    input  main_counter, winner_count, loser_count, WINNER, LOSER, GAMEOVER, WHO
  );

  modport slave (
    input  INIT, en, control, load_value,
    output main_counter, winner_count, loser_count, WINNER, LOSER, GAMEOVER, WHO
  );
endinterface

// File: rtl/counter_game_step.sv
// Combinational next-value calculation for the main counter, with wrap or
// saturate behaviour and boundary-hit flags on the resulting value.
module counter_game_step
  import counter_game_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STEP_SMALL = 1,
  parameter int unsigned STEP_BIG   = 2,
  parameter int unsigned SATURATE   = 0
) (
  input  logic [WIDTH-1:0] cur,
  input  ctrl_e            control,
  output logic [WIDTH-1:0] nxt,
  output logic             hit_max,
  output logic             hit_zero
);

  localparam logic [WIDTH:0] SMALL = (WIDTH+1)'(STEP_SMALL);
  localparam logic [WIDTH:0] BIG   = (WIDTH+1)'(STEP_BIG);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] mag;
  logic [WIDTH:0] sum;
  logic           dec;

  always_comb begin
    ext = {1'b0, cur};
    mag = SMALL;
    dec = 1'b0;
    unique case (control)
      CTRL_INC_S: begin mag = SMALL; dec = 1'b0; end
      CTRL_INC_B: begin mag = BIG;   dec = 1'b0; end
      CTRL_DEC_S: begin mag = SMALL; dec = 1'b1; end
      CTRL_DEC_B: begin mag = BIG;   dec = 1'b1; end
    endcase
    sum = dec ? (ext - mag) : (ext + mag);
    nxt = sum[WIDTH-1:0];
    // Top bit flags both overflow (increment) and borrow (decrement).
    if ((SATURATE != 0) && sum[WIDTH])
      nxt = dec ? '0 : '1;
    hit_max  = &nxt;
    hit_zero = ~|nxt;
  end

endmodule

// File: rtl/counter_game_param.sv
// Counter game engine: IDLE/RUN/OVER FSM, score registers and registered
// outputs behind the count interface.
module counter_game_param
  import counter_game_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned SCORE_LIMIT = 15,
  parameter int unsigned STEP_SMALL  = 1,
  parameter int unsigned STEP_BIG    = 2,
  parameter int unsigned SATURATE    = 0
) (
  input  logic          clk,
  input  logic          rst,
  counter_game_if.slave cg
);

  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(SCORE_LIMIT);

  state_e             state;
  logic [WIDTH-1:0]   cnt;
  logic [SCORE_W-1:0] win_n;
  logic [SCORE_W-1:0] los_n;
  logic               win_p;
  logic               los_p;
  logic               over;
  who_e               who;

  logic [WIDTH-1:0]   nxt;
  logic               hit_max;
  logic               hit_zero;
  logic [SCORE_W-1:0] win_inc;
  logic [SCORE_W-1:0] los_inc;

  counter_game_step #(
    .WIDTH      (WIDTH),
    .STEP_SMALL (STEP_SMALL),
    .STEP_BIG   (STEP_BIG),
    .SATURATE   (SATURATE)
  ) u_step (
    .cur      (cnt),
    .control  (ctrl_e'(cg.control)),
    .nxt      (nxt),
    .hit_max  (hit_max),
    .hit_zero (hit_zero)
  );

  always_comb begin
    win_inc = win_n + SCORE_W'(1);
    los_inc = los_n + SCORE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      win_n <= '0;
      los_n <= '0;
      win_p <= 1'b0;
      los_p <= 1'b0;
      over  <= 1'b0;
      who   <= WHO_NONE;
    end else if (cg.INIT) begin
      state <= RUN;
      cnt   <= cg.load_value;
      win_n <= '0;
      los_n <= '0;
      win_p <= 1'b0;
      los_p <= 1'b0;
      over  <= 1'b0;
      who   <= WHO_NONE;
    end else begin
      win_p <= 1'b0;
      los_p <= 1'b0;
      unique case (state)
        RUN: begin
          if (cg.en) begin
            cnt <= nxt;
            if (hit_max) begin
              win_n <= win_inc;
              win_p <= 1'b1;
              if (win_inc == LIMIT) begin
                state <= OVER;
                over  <= 1'b1;
                who   <= WHO_WINNER;
              end
            end else if (hit_zero) begin
              los_n <= los_inc;
              los_p <= 1'b1;
              if (los_inc == LIMIT) begin
                state <= OVER;
                over  <= 1'b1;
                who   <= WHO_LOSER;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cg.main_counter = cnt;
  assign cg.winner_count = win_n;
  assign cg.loser_count  = los_n;
  assign cg.WINNER       = win_p;
  assign cg.LOSER        = los_p;
  assign cg.GAMEOVER     = over;
  assign cg.WHO          = who;

endmodule

// File: tb/tb_counter_game_param.sv
// Bench for counter_game_param: a wrapping and a saturating instance share one
// stimulus stream and are both compared against an integer reference model.
module tb_counter_game_param;

  localparam int W    = 4;
  localparam int SW   = 4;
  localparam int LIM  = 15;
  localparam int SS   = 1;
  localparam int SB   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         init = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   control = 2'b00;
  logic [W-1:0] load_value = '0;

  int n_assert = 0;
  int n_fail   = 0;

  // index 0 = wrapping instance, 1 = saturating instance
  int m_cnt [2];
  int m_wn  [2];
  int m_ln  [2];
  int m_win [2];
  int m_los [2];
  int m_go  [2];
  int m_who [2];
  int m_run [2];

  counter_game_if #(.WIDTH(W), .SCORE_W(SW)) ifw ();
  counter_game_if #(.WIDTH(W), .SCORE_W(SW)) ifs ();

  assign ifw.INIT = init;
  assign ifw.en = en;
  assign ifw.control = control;
  assign ifw.load_value = load_value;
  assign ifs.INIT = init;
  assign ifs.en = en;
  assign ifs.control = control;
  assign ifs.load_value = load_value;

  counter_game_param #(
    .WIDTH(W), .SCORE_W(SW), .SCORE_LIMIT(LIM),
    .STEP_SMALL(SS), .STEP_BIG(SB), .SATURATE(0)
  ) dut_w (.clk(clk), .rst(rst), .cg(ifw.slave));

  counter_game_param #(
    .WIDTH(W), .SCORE_W(SW), .SCORE_LIMIT(LIM),
    .STEP_SMALL(SS), .STEP_BIG(SB), .SATURATE(1)
  ) dut_s (.clk(clk), .rst(rst), .cg(ifs.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Game rules evaluated on the inputs present just before the edge.
  task automatic model_edge();
    int delta;
    int n;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_cnt[m] = 0; m_wn[m] = 0; m_ln[m] = 0; m_win[m] = 0;
        m_los[m] = 0; m_go[m] = 0; m_who[m] = 0; m_run[m] = 0;
      end else if (init) begin
        m_cnt[m] = int'(load_value); m_wn[m] = 0; m_ln[m] = 0; m_win[m] = 0;
        m_los[m] = 0; m_go[m] = 0; m_who[m] = 0; m_run[m] = 1;
      end else begin
        m_win[m] = 0;
        m_los[m] = 0;
        if (m_run[m] == 1 && en) begin
          delta = control[0] ? SB : SS;
          n = control[1] ? m_cnt[m] - delta : m_cnt[m] + delta;
          if (m == 1) n = (n < 0) ? 0 : ((n > MAXV) ? MAXV : n);
          else        n = (n + MAXV + 1) % (MAXV + 1);
          m_cnt[m] = n;
          if (n == MAXV) begin
            m_wn[m]++; m_win[m] = 1;
            if (m_wn[m] == LIM) begin m_run[m] = 2; m_go[m] = 1; m_who[m] = 2; end
          end else if (n == 0) begin
            m_ln[m]++; m_los[m] = 1;
            if (m_ln[m] == LIM) begin m_run[m] = 2; m_go[m] = 1; m_who[m] = 1; end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("w.main_counter", 32'(ifw.main_counter), 32'(m_cnt[0]));
    chk("w.winner_count", 32'(ifw.winner_count), 32'(m_wn[0]));
    chk("w.loser_count",  32'(ifw.loser_count),  32'(m_ln[0]));
    chk("w.WINNER",       32'(ifw.WINNER),       32'(m_win[0]));
    chk("w.LOSER",        32'(ifw.LOSER),        32'(m_los[0]));
    chk("w.GAMEOVER",     32'(ifw.GAMEOVER),     32'(m_go[0]));
    chk("w.WHO",          32'(ifw.WHO),          32'(m_who[0]));
    chk("s.main_counter", 32'(ifs.main_counter), 32'(m_cnt[1]));
    chk("s.winner_count", 32'(ifs.winner_count), 32'(m_wn[1]));
    chk("s.loser_count",  32'(ifs.loser_count),  32'(m_ln[1]));
    chk("s.WINNER",       32'(ifs.WINNER),       32'(m_win[1]));
    chk("s.LOSER",        32'(ifs.LOSER),        32'(m_los[1]));
    chk("s.GAMEOVER",     32'(ifs.GAMEOVER),     32'(m_go[1]));
    chk("s.WHO",          32'(ifs.WHO),          32'(m_who[1]));
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_wn[m] = 0; m_ln[m] = 0; m_win[m] = 0;
      m_los[m] = 0; m_go[m] = 0; m_who[m] = 0; m_run[m] = 0;
    end

    // reset, then idle without INIT
    rst = 1; en = 1; control = 2'b00; init = 0;
    cyc(2);
    chk("rst_cnt_w", 32'(ifw.main_counter), 0);
    chk("rst_who_s", 32'(ifs.WHO), 0);
    rst = 0;
    cyc(1);
    chk("idle_cnt_w", 32'(ifw.main_counter), 0);

    // count up with wrap
    load_value = 1; init = 1;
    cyc(1);
    chk("load1_w", 32'(ifw.main_counter), 1);
    chk("load1_nowin", 32'(ifw.WINNER), 0);
    init = 0; control = 2'b00;
    cyc(13);
    chk("up14_w", 32'(ifw.main_counter), 14);
    cyc(1);
    chk("up15_w", 32'(ifw.main_counter), 15);
    chk("up15_WINNER", 32'(ifw.WINNER), 1);
    chk("up15_wc", 32'(ifw.winner_count), 1);
    cyc(1);
    chk("wrap0_w", 32'(ifw.main_counter), 0);
    chk("wrap0_LOSER", 32'(ifw.LOSER), 1);
    chk("wrap0_lc", 32'(ifw.loser_count), 1);
    chk("sat_hold_wc", 32'(ifs.winner_count), 2);

    // decrement wrap
    load_value = 1; init = 1;
    cyc(1);
    init = 0; control = 2'b11;
    cyc(1);
    chk("dec_wrap_w", 32'(ifw.main_counter), 15);
    chk("dec_wrap_WINNER", 32'(ifw.WINNER), 1);
    chk("dec_clamp_s", 32'(ifs.main_counter), 0);
    cyc(1);
    chk("dec13_w", 32'(ifw.main_counter), 13);
    chk("dec13_WINNER", 32'(ifw.WINNER), 0);

    // saturate at top
    load_value = 14; init = 1;
    cyc(1);
    init = 0; control = 2'b01;
    cyc(1);
    chk("sat15_s", 32'(ifs.main_counter), 15);
    chk("sat15_wc", 32'(ifs.winner_count), 1);
    cyc(1);
    chk("sat15b_wc", 32'(ifs.winner_count), 2);
    chk("sat15b_WINNER", 32'(ifs.WINNER), 1);
    control = 2'b10;
    cyc(1);
    chk("sat14_s", 32'(ifs.main_counter), 14);
    chk("sat14_WINNER", 32'(ifs.WINNER), 0);

    // game over by loser limit
    load_value = 1; init = 1;
    cyc(1);
    init = 0; control = 2'b10;
    cyc(14);
    chk("lose14_lc", 32'(ifs.loser_count), 14);
    chk("lose14_GO", 32'(ifs.GAMEOVER), 0);
    cyc(1);
    chk("lose15_lc", 32'(ifs.loser_count), 15);
    chk("lose15_LOSER", 32'(ifs.LOSER), 1);
    chk("lose15_GO", 32'(ifs.GAMEOVER), 1);
    chk("lose15_WHO", 32'(ifs.WHO), 1);
    control = 2'b01;
    cyc(3);
    chk("over_frozen", 32'(ifs.main_counter), 0);
    chk("over_LOSER", 32'(ifs.LOSER), 0);
    chk("over_GO", 32'(ifs.GAMEOVER), 1);
    load_value = 5; init = 1;
    cyc(1);
    init = 0;
    chk("restart_cnt", 32'(ifs.main_counter), 5);
    chk("restart_lc", 32'(ifs.loser_count), 0);
    chk("restart_GO", 32'(ifs.GAMEOVER), 0);
    chk("restart_WHO", 32'(ifs.WHO), 0);

    // pause, INIT priority, reset mid-run
    control = 2'b00;
    cyc(1);
    chk("step6_s", 32'(ifs.main_counter), 6);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("pause_cnt", 32'(ifs.main_counter), 6);
      chk("pause_WINNER", 32'(ifs.WINNER), 0);
    end
    en = 1; control = 2'b01; load_value = 7; init = 1;
    cyc(1);
    init = 0;
    chk("init_prio_s", 32'(ifs.main_counter), 7);
    chk("init_prio_w", 32'(ifw.main_counter), 7);
    cyc(2);
    chk("run11_s", 32'(ifs.main_counter), 11);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("midrst_cnt", 32'(ifs.main_counter), 0);
    chk("midrst_WINNER", 32'(ifs.WINNER), 0);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      init = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 3) != 0);
      control = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: load_value = '0;
        1: load_value = '1;
        default: load_value = W'($urandom_range(0, MAXV));
      endcase
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_game_param.md
Name: counter_game_param

Overview:
Parametrised next-generation counter game. A WIDTH-bit main counter moves by one of four signed steps per enabled cycle, selected by control. The block scores "winner" hits (counter reaches all-ones) and "loser" hits (counter reaches zero), and declares game over when either score reaches SCORE_LIMIT. It adds configurable width, step sizes, score limit, wrap/saturate mode, a pause input and an explicit FSM to the existing counter game, and sits behind the game's count interface as the game engine.

Parameters:
WIDTH, 4, main counter width (>=2)
SCORE_W, 4, score counter width; must satisfy 2**SCORE_W > SCORE_LIMIT
SCORE_LIMIT, 15, score value that ends the game (>=1)
STEP_SMALL, 1, magnitude for control 00/10 (1..2**WIDTH-1)
STEP_BIG, 2, magnitude for control 01/11 (1..2**WIDTH-1)
SATURATE, 0, 0 = counter wraps modulo 2**WIDTH; 1 = counter clamps at 0 / all-ones

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous reset, active-high
INIT  in  1  load load_value, clear scores, start game
en  in  1  step enable; 0 = pause
control  in  2  00 +STEP_SMALL, 01 +STEP_BIG, 10 -STEP_SMALL, 11 -STEP_BIG
load_value  in  WIDTH  value loaded on INIT
main_counter  out  WIDTH  current counter (registered)
winner_count  out  SCORE_W  number of winner hits
loser_count  out  SCORE_W  number of loser hits
WINNER  out  1  one-cycle pulse on a winner hit
LOSER  out  1  one-cycle pulse on a loser hit
GAMEOVER  out  1  level; high while in OVER state
WHO  out  2  00 none, 01 loser reached limit, 10 winner reached limit

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; main_counter, winner_count, loser_count, WINNER, LOSER, GAMEOVER and WHO all 0. Reset overrides INIT. Reset mid-game aborts the game with no residual pulse.
- All outputs are registered and update on the edge where the causing event is sampled (latency 1 cycle).
- FSM states: IDLE, RUN, OVER.
  - IDLE: counter holds; waits for INIT.
  - RUN: steps while en=1.
  - OVER: everything frozen; only INIT or rst leave it.
- Priority within a cycle: rst > INIT > step.
- INIT, in any state: main_counter<=load_value; scores<=0; WINNER/LOSER/GAMEOVER/WHO<=0; state<=RUN. The load itself never scores, even when load_value is 0 or all-ones.
- Step (RUN, en=1, INIT=0):
  - nxt = main_counter ± step, computed in WIDTH+1 bits.
  - SATURATE=0: keep the low WIDTH bits (wrap-around).
  - SATURATE=1: clamp to [0, 2**WIDTH-1].
  - main_counter<=nxt.
- Scoring: evaluated on nxt, every step cycle.
  - nxt == all-ones: WINNER<=1 and winner_count++.
  - nxt == 0: LOSER<=1 and loser_count++.
  - Both cannot occur together (WIDTH>=2).
  - Holding at a boundary in saturate mode scores again every cycle.
- Pulses: WINNER and LOSER are 0 in every cycle without a hit, including pause cycles, IDLE and OVER.
- Game over: if the incremented score equals SCORE_LIMIT, then on the same edge state<=OVER, GAMEOVER<=1, WHO<=10 (winner) or 01 (loser). The final WINNER/LOSER pulse is still emitted on that edge.
- Pause (en=0 in RUN): counter, scores and WHO hold; pulses 0.
- Scores never exceed SCORE_LIMIT (the game stops first); no score wrap.

Decomposition:
- Package counter_game_pkg:
  - ctrl_e: CTRL_INC_S=2'b00, CTRL_INC_B=2'b01, CTRL_DEC_S=2'b10, CTRL_DEC_B=2'b11
  - who_e: WHO_NONE=2'b00, WHO_LOSER=2'b01, WHO_WINNER=2'b10
  - state_e: IDLE, RUN, OVER
- Sub-module counter_game_step: combinational; inputs cur and control; parameters WIDTH, STEP_SMALL, STEP_BIG, SATURATE; outputs nxt, hit_max, hit_zero.
- The top module holds the FSM, the score registers and the output registers.

Test Plan:
1. Reset: rst=1 for 2 cycles with INIT=0, en=1, control=00 → all outputs 0, main_counter stays 0. Then rst=0 without INIT → still 0 (IDLE).
2. Wrap (defaults): load_value=1, INIT pulse, en=1, control=00 → main_counter 1,2,…,15. WINNER=1 and winner_count=1 on the edge reaching 15. The next edge gives 0 with LOSER=1 and loser_count=1.
3. Decrement wrap: load_value=1, control=11 → main_counter=15 after one step, WINNER=1, winner_count=1. A second step gives 13 with no pulse.
4. Saturate (SATURATE=1): load_value=14, control=01 → 15 with winner_count=1. Holding control=01 → 15 again with winner_count=2. Control=10 → 14 with no pulse.
5. Game over (SATURATE=1): load_value=1, control=10 → 0, then loser hit every cycle. On the 15th hit: loser_count=15, LOSER=1, GAMEOVER=1, WHO=01. Further control is ignored (counter stays 0, no pulses). INIT with load_value=5 → RUN, scores 0, GAMEOVER=0, WHO=00, main_counter=5.
6. Pause/priority: en=0 for 5 cycles mid-run → counter and scores frozen, pulses 0. INIT=1 with en=1, control=01, load_value=7 → main_counter=7 (not 9). rst=1 mid-run → all outputs 0 on the next edge.
